ram_b_ctrl: RTL and testbench



---
 rtl/ram_b_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_ram_b_ctrl.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_b_ctrl.sv
// ram_b_ctrl: owner of the sequence-B character RAM.
// Loads sequence B from a valid/ready character stream, validating each base code and
// counting characters, then arbitrates RAM reads between the traceback engine (higher
// priority) and the matrix-fill engine. All RAM port signals are driven from registers here;
// read data comes back two cycles after the grant, tagged with the requester that owns it.
module ram_b_ctrl #(
  parameter int unsigned N       = 128,
  parameter int unsigned BitAddr = $clog2(N + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  // Load control and character stream
  input  logic             load_start,
  input  logic             s_valid,
  input  logic [2:0]       s_data,
  input  logic             s_last,
  output logic             s_ready,
  // Read requesters
  input  logic             fill_req,
  input  logic [BitAddr:0] fill_idx,
  input  logic             trace_req,
  input  logic [BitAddr:0] trace_idx,
  output logic             fill_gnt,
  output logic             trace_gnt,
  output logic             oob,
  // Read return
  output logic             rd_valid,
  output logic             rd_owner,
  output logic [2:0]       rd_data,
  // Status
  output logic [BitAddr:0] len,
  output logic             loaded,
  output logic [1:0]       err,
  // RAM write port
  output logic [2:0]       ram_din,
  output logic             ram_en_din,
  output logic             ram_we,
  output logic [BitAddr:0] ram_addr_din,
  // RAM read port
  output logic             ram_en_dout,
  output logic [BitAddr:0] ram_addr_dout,
  input  logic [2:0]       ram_dout
);

  // Legal base codes
  localparam logic [2:0] CodeG = 3'b001;
  localparam logic [2:0] CodeC = 3'b110;
  localparam logic [2:0] CodeA = 3'b100;
  localparam logic [2:0] CodeT = 3'b011;

  // Error codes reported on err
  localparam logic [1:0] ErrNone = 2'd0;
  localparam logic [1:0] ErrCode = 2'd1;
  localparam logic [1:0] ErrOvf  = 2'd2;

  localparam logic [BitAddr:0] LenMax = N[BitAddr:0];

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StReady,
    StErr
  } state_e;

  state_e           state_q;
  logic [BitAddr:0] len_q;
  logic [1:0]       err_q;
  logic             s_ready_q;
  logic             loaded_q;

  // Write port registers
  logic             ram_wr_q;
  logic [BitAddr:0] ram_addr_din_q;
  logic [2:0]       ram_din_q;

  // Read port and return pipeline registers
  logic             ram_en_dout_q;
  logic [BitAddr:0] ram_addr_dout_q;
  logic             owner_pipe_q;
  logic             rd_valid_q;
  logic             rd_owner_q;
  logic             oob_q;

  logic             code_legal;
  logic             hs;
  logic             wr_fire;
  logic [BitAddr:0] len_inc;
  logic             is_ready;
  logic             gnt_trace;
  logic             gnt_fill;
  logic             gnt_any;
  logic [BitAddr:0] gnt_idx;
  logic             gnt_in_range;

  // Classify the incoming character code
  always_comb begin
    code_legal = 1'b0;
    unique case (s_data)
      CodeG, CodeC, CodeA, CodeT: code_legal = 1'b1;
      default:                    code_legal = 1'b0;
    endcase
  end

  assign hs      = s_valid & s_ready_q;
  // A load_start in the same cycle as a handshake restarts the load; that character is dropped.
  assign wr_fire = hs & code_legal & ~load_start;
  assign len_inc = len_q + 1'b1;

  // Fixed-priority read arbitration: trace wins, only in READY
  always_comb begin
    is_ready     = (state_q == StReady);
    gnt_trace    = is_ready & trace_req;
    gnt_fill     = is_ready & fill_req & ~trace_req;
    gnt_any      = gnt_trace | gnt_fill;
    gnt_idx      = trace_req ? trace_idx : fill_idx;
    gnt_in_range = (gnt_idx < len_q);
  end

  // Control FSM: state, length, error code and the registered stream/status outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      len_q     <= '0;
      err_q     <= ErrNone;
      s_ready_q <= 1'b0;
      loaded_q  <= 1'b0;
    end else if (load_start) begin
      state_q   <= StLoad;
      len_q     <= '0;
      err_q     <= ErrNone;
      s_ready_q <= 1'b1;
      loaded_q  <= 1'b0;
    end else begin
      case (state_q)
        StLoad: begin
          if (hs) begin
            if (!code_legal) begin
              state_q   <= StErr;
              err_q     <= ErrCode;
              s_ready_q <= 1'b0;
            end else begin
              len_q <= len_inc;
              if (s_last) begin
                state_q   <= StReady;
                s_ready_q <= 1'b0;
                loaded_q  <= 1'b1;
              end else if (len_inc == LenMax) begin
                // The N-th character is kept; any further one would not fit.
                state_q   <= StErr;
                err_q     <= ErrOvf;
                s_ready_q <= 1'b0;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  // RAM write port: a legal handshake becomes a one-cycle write strobe in the next cycle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ram_wr_q       <= 1'b0;
      ram_addr_din_q <= '0;
      ram_din_q      <= '0;
    end else begin
      ram_wr_q <= wr_fire;
      if (wr_fire) begin
        ram_addr_din_q <= len_q;
        ram_din_q      <= s_data;
      end
    end
  end

  // RAM read port: in-range grants issue a read next cycle, out-of-range ones pulse oob
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ram_en_dout_q   <= 1'b0;
      ram_addr_dout_q <= '0;
      owner_pipe_q    <= 1'b0;
      oob_q           <= 1'b0;
    end else begin
      ram_en_dout_q <= gnt_any & gnt_in_range;
      oob_q         <= gnt_any & ~gnt_in_range;
      if (gnt_any & gnt_in_range) begin
        ram_addr_dout_q <= gnt_idx;
        owner_pipe_q    <= gnt_trace;
      end
    end
  end

  // Read return: the RAM registers its data during the strobe cycle, so tag it one cycle later
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_valid_q <= 1'b0;
      rd_owner_q <= 1'b0;
    end else begin
      rd_valid_q <= ram_en_dout_q;
      if (ram_en_dout_q) begin
        rd_owner_q <= owner_pipe_q;
      end
    end
  end

  assign s_ready       = s_ready_q;
  assign loaded        = loaded_q;
  assign len           = len_q;
  assign err           = err_q;
  assign trace_gnt     = gnt_trace;
  assign fill_gnt      = gnt_fill;
  assign oob           = oob_q;
  assign rd_valid      = rd_valid_q;
  assign rd_owner      = rd_owner_q;
  assign rd_data       = ram_dout;
  assign ram_din       = ram_din_q;
  assign ram_en_din    = ram_wr_q;
  assign ram_we        = ram_wr_q;
  assign ram_addr_din  = ram_addr_din_q;
  assign ram_en_dout   = ram_en_dout_q;
  assign ram_addr_dout = ram_addr_dout_q;

endmodule

// File: tb/tb_ram_b_ctrl.sv
// Testbench for ram_b_ctrl: directed scenarios plus randomized loads/reads, checked against
// a queue-based model of the stored sequence and a per-cycle expectation monitor.
module tb_ram_b_ctrl;

  localparam int unsigned N       = 128;
  localparam int unsigned BitAddr = $clog2(N + 1);

  localparam int MIdle  = 0;
  localparam int MLoad  = 1;
  localparam int MReady = 2;
  localparam int MErr   = 3;

  typedef struct {
    int             cyc;
    logic [BitAddr:0] addr;
    logic [2:0]     data;
    bit             owner;
  } ev_t;

  logic             clk = 1'b0;
  logic             rst_ni = 1'b1;
  logic             load_start = 1'b0;
  logic             s_valid = 1'b0;
  logic [2:0]       s_data = '0;
  logic             s_last = 1'b0;
  logic             s_ready;
  logic             fill_req = 1'b0;
  logic [BitAddr:0] fill_idx = '0;
  logic             trace_req = 1'b0;
  logic [BitAddr:0] trace_idx = '0;
  logic             fill_gnt, trace_gnt, oob;
  logic             rd_valid, rd_owner;
  logic [2:0]       rd_data;
  logic [BitAddr:0] len;
  logic             loaded;
  logic [1:0]       err;
  logic [2:0]       ram_din;
  logic             ram_en_din, ram_we;
  logic [BitAddr:0] ram_addr_din;
  logic             ram_en_dout;
  logic [BitAddr:0] ram_addr_dout;
  logic [2:0]       ram_dout = '0;

  logic [2:0] mem [N];
  logic [2:0] codes [4] = '{3'b001, 3'b110, 3'b100, 3'b011};

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wr_cnt = 0;
  bit mon_en = 1'b0;
  bit mon_hit;

  // Model state
  logic [2:0] ref_seq [$];
  int         ref_st = MIdle;
  int         ref_err = 0;
  ev_t        exp_wr [$];
  ev_t        exp_en [$];
  ev_t        exp_rd [$];
  ev_t        exp_oob [$];

  always #5 clk = ~clk;

  ram_b_ctrl #(.N(N), .BitAddr(BitAddr)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .load_start   (load_start),
    .s_valid      (s_valid),
    .s_data       (s_data),
    .s_last       (s_last),
    .s_ready      (s_ready),
    .fill_req     (fill_req),
    .fill_idx     (fill_idx),
    .trace_req    (trace_req),
    .trace_idx    (trace_idx),
    .fill_gnt     (fill_gnt),
    .trace_gnt    (trace_gnt),
    .oob          (oob),
    .rd_valid     (rd_valid),
    .rd_owner     (rd_owner),
    .rd_data      (rd_data),
    .len          (len),
    .loaded       (loaded),
    .err          (err),
    .ram_din      (ram_din),
    .ram_en_din   (ram_en_din),
    .ram_we       (ram_we),
    .ram_addr_din (ram_addr_din),
    .ram_en_dout  (ram_en_dout),
    .ram_addr_dout(ram_addr_dout),
    .ram_dout     (ram_dout)
  );

  // Character RAM with registered read
  always @(posedge clk) begin
    if (ram_en_din && ram_we) mem[ram_addr_din[6:0]] <= ram_din;
    if (ram_en_dout) ram_dout <= mem[ram_addr_dout[6:0]];
  end

  always @(posedge clk) begin
    cyc++;
    if (ram_en_din && ram_we) wr_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Per-cycle check of every strobe against the expectation queues
  always @(negedge clk) begin
    if (mon_en) begin
      mon_hit = (exp_wr.size() > 0) && (exp_wr[0].cyc == cyc);
      chk("wr_strobe", {ram_en_din, ram_we}, mon_hit ? 2'b11 : 2'b00);
      if (mon_hit) begin
        chk("wr_addr", ram_addr_din, exp_wr[0].addr);
        chk("wr_data", ram_din, exp_wr[0].data);
        void'(exp_wr.pop_front());
      end
      mon_hit = (exp_en.size() > 0) && (exp_en[0].cyc == cyc);
      chk("rd_strobe", ram_en_dout, mon_hit);
      if (mon_hit) begin
        chk("rd_addr", ram_addr_dout, exp_en[0].addr);
        void'(exp_en.pop_front());
      end
      mon_hit = (exp_rd.size() > 0) && (exp_rd[0].cyc == cyc);
      chk("rd_valid", rd_valid, mon_hit);
      if (mon_hit) begin
        chk("rd_owner", rd_owner, exp_rd[0].owner);
        chk("rd_data", rd_data, exp_rd[0].data);
        void'(exp_rd.pop_front());
      end
      mon_hit = (exp_oob.size() > 0) && (exp_oob[0].cyc == cyc);
      chk("oob", oob, mon_hit);
      if (mon_hit) void'(exp_oob.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit legal(input logic [2:0] c);
    return c inside {3'b001, 3'b110, 3'b100, 3'b011};
  endfunction

  task automatic do_load_start();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    ref_seq.delete();
    ref_err = 0;
    ref_st = MLoad;
  endtask

  // Offer one character after 'gap' idle cycles; model decides what the DUT must do
  task automatic send(input logic [2:0] code, input bit last, input int gap);
    bit  exp_rdy;
    ev_t e;
    for (int g = 0; g < gap; g++) begin
      s_valid = 1'b0;
      @(negedge clk);
      chk("s_ready_gap", s_ready, ref_st == MLoad);
      tick();
    end
    s_valid = 1'b1;
    s_data  = code;
    s_last  = last;
    exp_rdy = (ref_st == MLoad);
    if (exp_rdy) begin
      if (legal(code)) begin
        e.cyc   = cyc + 1;
        e.addr  = (BitAddr + 1)'(ref_seq.size());
        e.data  = code;
        e.owner = 1'b0;
        exp_wr.push_back(e);
        ref_seq.push_back(code);
        if (last) ref_st = MReady;
        else if (ref_seq.size() == N) begin
          ref_st  = MErr;
          ref_err = 2;
        end
      end else begin
        ref_st  = MErr;
        ref_err = 1;
      end
    end
    @(negedge clk);
    chk("s_ready", s_ready, exp_rdy);
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic check_status(input string tag);
    @(negedge clk);
    chk({tag, "_len"}, len, ref_seq.size());
    chk({tag, "_err"}, err, ref_err);
    chk({tag, "_loaded"}, loaded, ref_st == MReady);
    chk({tag, "_s_ready"}, s_ready, ref_st == MLoad);
    tick();
  endtask

  // One request cycle; eg_f reports whether the model grants the fill requester
  task automatic req_cycle(input bit tr, input logic [BitAddr:0] ti, input bit fr,
                           input logic [BitAddr:0] fi, output bit eg_f);
    bit               rdy, eg_t;
    logic [BitAddr:0] idx;
    ev_t              e;
    trace_req = tr;
    trace_idx = ti;
    fill_req  = fr;
    fill_idx  = fi;
    rdy  = (ref_st == MReady);
    eg_t = rdy && tr;
    eg_f = rdy && fr && !tr;
    if (eg_t || eg_f) begin
      idx = eg_t ? ti : fi;
      if (int'(idx) < ref_seq.size()) begin
        e.cyc = cyc + 1; e.addr = idx; e.data = ref_seq[idx]; e.owner = eg_t;
        exp_en.push_back(e);
        e.cyc = cyc + 2;
        exp_rd.push_back(e);
      end else begin
        e.cyc = cyc + 1; e.addr = idx; e.data = '0; e.owner = eg_t;
        exp_oob.push_back(e);
      end
    end
    @(negedge clk);
    chk("trace_gnt", trace_gnt, eg_t);
    chk("fill_gnt", fill_gnt, eg_f);
    tick();
    trace_req = 1'b0;
    fill_req  = 1'b0;
  endtask

  // Random requesters; a fill that loses arbitration holds its request and index
  task automatic read_phase(input int ncyc);
    bit               fp, tr, eg;
    logic [BitAddr:0] fi, ti;
    int unsigned      hi;
    fp = 1'b0;
    fi = '0;
    hi = ref_seq.size() + 1;
    for (int k = 0; k < ncyc; k++) begin
      if (!fp) begin
        fp = ($urandom_range(0, 3) != 0);
        fi = (BitAddr + 1)'($urandom_range(0, hi));
      end
      tr = ($urandom_range(0, 2) == 0);
      ti = (BitAddr + 1)'($urandom_range(0, hi));
      req_cycle(tr, ti, fp, fi, eg);
      if (eg) fp = 1'b0;
    end
    repeat (3) tick();
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, {s_ready, fill_gnt, trace_gnt, oob, rd_valid, rd_owner, len, loaded, err,
              ram_din, ram_en_din, ram_we, ram_addr_din, ram_en_dout, ram_addr_dout}, 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "timeout");
  end

  initial begin
    bit g;
    int w0;
    logic [2:0] gatgc [5] = '{3'b001, 3'b100, 3'b011, 3'b001, 3'b110};

    // Reset state
    #1 rst_ni = 1'b0;
    @(negedge clk);
    chk_all_zero("reset_outputs");
    tick();
    tick();
    rst_ni = 1'b1;
    mon_en = 1'b1;
    check_status("idle");

    // Load G,A,T,G,C and read back 0..4 back-to-back
    do_load_start();
    for (int i = 0; i < 5; i++) send(gatgc[i], i == 4, 0);
    for (int i = 0; i < 5; i++) req_cycle(1'b0, '0, 1'b1, (BitAddr + 1)'(i), g);
    repeat (3) tick();
    check_status("gatgc");

    // Trace idx1 and fill idx3 collide; fill holds and wins next cycle
    req_cycle(1'b1, 9'd1, 1'b1, 9'd3, g);
    chk("collide_fill_lost", g, 1'b0);
    req_cycle(1'b0, '0, 1'b1, 9'd3, g);
    repeat (3) tick();

    // Out-of-range index at len
    req_cycle(1'b0, '0, 1'b1, 9'd5, g);
    repeat (3) tick();

    // Illegal code as second character
    do_load_start();
    send(3'b100, 1'b0, 0);
    send(3'b000, 1'b0, 0);
    check_status("illegal");
    req_cycle(1'b1, 9'd0, 1'b1, 9'd0, g);
    send(3'b001, 1'b0, 0);
    do_load_start();
    check_status("restart");

    // Overflow: N characters without s_last
    do_load_start();
    w0 = wr_cnt;
    for (int i = 0; i < N; i++) send(codes[$urandom_range(0, 3)], 1'b0, 0);
    check_status("overflow");
    chk("overflow_writes", wr_cnt - w0, N);
    send(3'b001, 1'b0, 0);
    check_status("overflow_hold");

    // Last character read immediately after READY
    do_load_start();
    send(3'b011, 1'b0, 0);
    send(3'b110, 1'b1, 0);
    req_cycle(1'b1, 9'd1, 1'b0, '0, g);
    repeat (3) tick();

    // Randomized loads and reads
    for (int it = 0; it < 6; it++) begin
      int unsigned l;
      do_load_start();
      l = $urandom_range(1, 24);
      for (int i = 0; i < int'(l); i++) begin
        send(codes[$urandom_range(0, 3)], i == int'(l) - 1, int'($urandom_range(0, 1)));
      end
      read_phase(30);
      check_status("rand");
    end

    // Reset mid-load after three characters
    do_load_start();
    for (int i = 0; i < 3; i++) send(codes[i], 1'b0, 0);
    rst_ni = 1'b0;
    exp_wr.delete();
    exp_en.delete();
    exp_rd.delete();
    exp_oob.delete();
    ref_seq.delete();
    ref_st = MIdle;
    ref_err = 0;
    #1;
    chk_all_zero("midload_reset");
    w0 = wr_cnt;
    tick();
    chk("midload_no_write", wr_cnt, w0);
    chk_all_zero("midload_reset_hold");
    rst_ni = 1'b1;
    check_status("after_reset");
    send(3'b001, 1'b0, 0);
    check_status("after_reset_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
